// File: rtl/serial_frame_receiver_16_bit_if.sv
// Handshake/status bundle for serial_frame_receiver_16_bit.
// PARITY_CHECK_EN adds Parity_Error_Out to the bundle.
interface serial_frame_receiver_16_bit_if;
    logic        Enable_In;
    logic        Shift_Data_Signal_In;
    logic        Serial_Data_In;
    logic        Frame_Start_In;
    logic        Data_Ready_In;
    logic        Clear_Overrun_In;
    logic [15:0] Parallel_Data_Out;
    logic        Data_Valid_Out;
    logic        Busy_Out;
    logic [4:0]  Bit_Count_Out;
    logic        Overrun_Out;
    logic        Frame_Error_Out;
`ifdef PARITY_CHECK_EN
    logic        Parity_Error_Out;

    modport slave (
        input  Enable_In, Shift_Data_Signal_In, Serial_Data_In, Frame_Start_In,
               Data_Ready_In, Clear_Overrun_In,
        output Parallel_Data_Out, Data_Valid_Out, Busy_Out, Bit_Count_Out,
               Overrun_Out, Frame_Error_Out, Parity_Error_Out
    );
    modport master (
        output Enable_In, Shift_Data_Signal_In, Serial_Data_In, Frame_Start_In,
               Data_Ready_In, Clear_Overrun_In,
        input  Parallel_Data_Out, Data_Valid_Out, Busy_Out, Bit_Count_Out,
               Overrun_Out, Frame_Error_Out, Parity_Error_Out
    );
`else
    modport slave (
        input  Enable_In, Shift_Data_Signal_In, Serial_Data_In, Frame_Start_In,
               Data_Ready_In, Clear_Overrun_In,
        output Parallel_Data_Out, Data_Valid_Out, Busy_Out, Bit_Count_Out,
               Overrun_Out, Frame_Error_Out
    );
    modport master (
        output Enable_In, Shift_Data_Signal_In, Serial_Data_In, Frame_Start_In,
               Data_Ready_In, Clear_Overrun_In,
        input  Parallel_Data_Out, Data_Valid_Out, Busy_Out, Bit_Count_Out,
               Overrun_Out, Frame_Error_Out
    );
`endif
endinterface

// File: rtl/serial_frame_receiver_16_bit.sv
// MSB-first serial-to-parallel frame receiver with a one-word holding register.
// PARITY_CHECK_EN: 17-bit frames, last bit is even parity over the 16 data bits.
module serial_frame_receiver_16_bit (
    input logic                            Clk_In,
    input logic                            Reset_In,
    serial_frame_receiver_16_bit_if.slave  bus
);
    localparam int unsigned DATA_W = 16;
    localparam int unsigned CNT_W  = 5;
`ifdef PARITY_CHECK_EN
    localparam int unsigned FRAME_LEN = 17;
`else
    localparam int unsigned FRAME_LEN = 16;
`endif

    localparam logic [0:0] IDLE    = 1'b0;
    localparam logic [0:0] RECEIVE = 1'b1;

    logic [0:0]        state_q, state_n;
    logic [DATA_W-1:0] shift_q, shift_n;
    logic [DATA_W-1:0] data_q, data_n;
    logic [CNT_W-1:0]  count_q, count_n;
    logic              valid_q, valid_n;
    logic              busy_q, busy_n;
    logic              overrun_q, overrun_n;
    logic              frame_err_q, frame_err_n;
    logic              accept_c, complete_c;
    logic              overrun_set_c, frame_err_set_c;
    logic [DATA_W-1:0] word_c;
`ifdef PARITY_CHECK_EN
    logic              parity_err_q, parity_err_n;
    logic              parity_err_set_c;
`endif

    // Next-state, datapath and handshake decode
    always_comb begin
        state_n         = state_q;
        shift_n         = shift_q;
        data_n          = data_q;
        count_n         = count_q;
        valid_n         = valid_q;
        overrun_n       = overrun_q;
        frame_err_n     = frame_err_q;
        overrun_set_c   = 1'b0;
        frame_err_set_c = 1'b0;
        complete_c      = 1'b0;
        accept_c        = bus.Enable_In & bus.Shift_Data_Signal_In;
`ifdef PARITY_CHECK_EN
        parity_err_n     = parity_err_q;
        parity_err_set_c = 1'b0;
        word_c           = shift_q;
`else
        word_c           = {shift_q[DATA_W-2:0], bus.Serial_Data_In};
`endif

        case (state_q)
            IDLE: begin
                if (accept_c) begin
                    state_n = RECEIVE;
                    shift_n = DATA_W'(bus.Serial_Data_In);
                    count_n = CNT_W'(1);
                end
            end
            RECEIVE: begin
                if (accept_c) begin
                    if (bus.Frame_Start_In) begin
                        // restart: the partial word is discarded
                        shift_n         = DATA_W'(bus.Serial_Data_In);
                        count_n         = CNT_W'(1);
                        frame_err_set_c = 1'b1;
                    end else begin
                        count_n = count_q + CNT_W'(1);
                        if (count_q < CNT_W'(DATA_W)) begin
                            shift_n = {shift_q[DATA_W-2:0], bus.Serial_Data_In};
                        end
`ifdef PARITY_CHECK_EN
                        if (count_q == CNT_W'(DATA_W) && ((^shift_q) != bus.Serial_Data_In)) begin
                            parity_err_set_c = 1'b1;
                        end
`endif
                        if (count_q == CNT_W'(FRAME_LEN - 1)) begin
                            complete_c = 1'b1;
                            state_n    = IDLE;
                            count_n    = '0;
                        end
                    end
                end
            end
            default: begin
                state_n = IDLE;
                count_n = '0;
            end
        endcase

        if (complete_c) begin
            if (!valid_q || bus.Data_Ready_In) begin
                data_n  = word_c;
                valid_n = 1'b1;
            end else begin
                overrun_set_c = 1'b1;
            end
        end else if (valid_q && bus.Data_Ready_In) begin
            valid_n = 1'b0;
        end

        // clear first so a same-edge set event wins
        if (bus.Clear_Overrun_In) begin
            overrun_n   = 1'b0;
            frame_err_n = 1'b0;
`ifdef PARITY_CHECK_EN
            parity_err_n = 1'b0;
`endif
        end
        if (overrun_set_c)   overrun_n   = 1'b1;
        if (frame_err_set_c) frame_err_n = 1'b1;
`ifdef PARITY_CHECK_EN
        if (parity_err_set_c) parity_err_n = 1'b1;
`endif

        busy_n = (state_n == RECEIVE);
    end

    // State and output registers
    always_ff @(posedge Clk_In) begin
        if (Reset_In) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            data_q      <= '0;
            count_q     <= '0;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
`ifdef PARITY_CHECK_EN
            parity_err_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_n;
            shift_q     <= shift_n;
            data_q      <= data_n;
            count_q     <= count_n;
            valid_q     <= valid_n;
            busy_q      <= busy_n;
            overrun_q   <= overrun_n;
            frame_err_q <= frame_err_n;
`ifdef PARITY_CHECK_EN
            parity_err_q <= parity_err_n;
`endif
        end
    end

    assign bus.Parallel_Data_Out = data_q;
    assign bus.Data_Valid_Out    = valid_q;
    assign bus.Busy_Out          = busy_q;
    assign bus.Bit_Count_Out     = count_q;
    assign bus.Overrun_Out       = overrun_q;
    assign bus.Frame_Error_Out   = frame_err_q;
`ifdef PARITY_CHECK_EN
    assign bus.Parity_Error_Out  = parity_err_q;
`endif

endmodule

// File: tb/tb_serial_frame_receiver_16_bit.sv
// Bench for serial_frame_receiver_16_bit: directed table, corner sequences and
// randomized traffic checked every cycle against a bit-queue reference model.
module tb_serial_frame_receiver_16_bit;
`ifdef PARITY_CHECK_EN
    localparam int NBITS = 17;
`else
    localparam int NBITS = 16;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;
    bit   chk_on  = 1'b0;

    serial_frame_receiver_16_bit_if bus();

    serial_frame_receiver_16_bit dut (
        .Clk_In   (clk),
        .Reset_In (rst),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    // Reference model: received bits held in a queue, word packed arithmetically
    int          bits[$];
    logic [15:0] m_data  = '0;
    bit          m_valid = 0;
    bit          m_ovr   = 0;
    bit          m_ferr  = 0;
    bit          m_perr  = 0;

    always @(posedge clk) begin
        bit          done, s_ovr, s_ferr, s_perr;
        int          ones;
        logic [15:0] w;
        done = 0; s_ovr = 0; s_ferr = 0; s_perr = 0; w = '0;
        if (rst) begin
            bits.delete();
            m_data = '0; m_valid = 0; m_ovr = 0; m_ferr = 0; m_perr = 0;
        end else begin
            if (bus.Enable_In && bus.Shift_Data_Signal_In) begin
                if (bits.size() > 0 && bus.Frame_Start_In) begin
                    bits.delete();
                    s_ferr = 1;
                end
                bits.push_back(bus.Serial_Data_In ? 1 : 0);
                if (bits.size() == NBITS) begin
                    ones = 0;
                    for (int i = 0; i < 16; i++) begin
                        w    = w * 16'd2 + 16'(bits[i]);
                        ones = ones + bits[i];
                    end
                    if (NBITS == 17 && (ones % 2) != bits[16]) s_perr = 1;
                    done = 1;
                    bits.delete();
                end
            end
            if (done) begin
                if (!m_valid || bus.Data_Ready_In) begin
                    m_data  = w;
                    m_valid = 1;
                end else begin
                    s_ovr = 1;
                end
            end else if (m_valid && bus.Data_Ready_In) begin
                m_valid = 0;
            end
            if (bus.Clear_Overrun_In) begin
                m_ovr = 0; m_ferr = 0; m_perr = 0;
            end
            m_ovr  = m_ovr  | s_ovr;
            m_ferr = m_ferr | s_ferr;
            m_perr = m_perr | s_perr;
        end
    end

    function automatic logic [25:0] act_vec();
        logic perr;
`ifdef PARITY_CHECK_EN
        perr = bus.Parity_Error_Out;
`else
        perr = 1'b0;
`endif
        return {bus.Parallel_Data_Out, bus.Data_Valid_Out, bus.Busy_Out,
                bus.Overrun_Out, bus.Frame_Error_Out, bus.Bit_Count_Out, perr};
    endfunction

    // Cycle-by-cycle comparison against the model
    always @(negedge clk) begin
        logic [25:0] exp;
        if (chk_on) begin
            exp = {m_data, m_valid, 1'(bits.size() > 0), m_ovr, m_ferr,
                   5'(bits.size()), m_perr};
            n_tests++;
            if (act_vec() !== exp) begin
                n_fail++;
                $display("FAIL model_cycle t=%0t got {data,v,busy,ovr,ferr,cnt,perr}=%h required %h",
                         $time, act_vec(), exp);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus.Enable_In            = 1'b1;
        bus.Shift_Data_Signal_In = 1'b0;
        bus.Serial_Data_In       = 1'b0;
        bus.Frame_Start_In       = 1'b0;
        bus.Data_Ready_In        = 1'b0;
        bus.Clear_Overrun_In     = 1'b0;
    endtask

    task automatic strobe_bit(input logic b, input logic fs, input logic rdy);
        bus.Enable_In            = 1'b1;
        bus.Shift_Data_Signal_In = 1'b1;
        bus.Serial_Data_In       = b;
        bus.Frame_Start_In       = fs;
        bus.Data_Ready_In        = rdy;
        tick();
        idle_inputs();
    endtask

    task automatic send_word(input logic [15:0] w, input logic fs_first, input logic rdy_last);
`ifdef PARITY_CHECK_EN
        for (int i = 15; i >= 0; i--) strobe_bit(w[i], fs_first && i == 15, 1'b0);
        strobe_bit(^w, 1'b0, rdy_last);
`else
        for (int i = 15; i >= 0; i--) strobe_bit(w[i], fs_first && i == 15, rdy_last && i == 0);
`endif
    endtask

    task automatic pulse(input int which);
        if (which == 0) rst = 1'b1;
        if (which == 1) bus.Clear_Overrun_In = 1'b1;
        if (which == 2) bus.Data_Ready_In = 1'b1;
        tick();
        rst = 1'b0;
        idle_inputs();
    endtask

    typedef struct {
        logic [15:0] word;
        bit          do_send;
        int          partial;
        bit          reset_mid;
        bit          fs_restart;
        bit          rdy_last;
        bit          clear_before;
        bit          drain_before;
        logic [15:0] exp_data;
        bit          exp_valid;
        bit          exp_ovr;
        bit          exp_ferr;
    } vec_t;

    vec_t tbl[8];

    initial begin
        logic [15:0] w;
        logic [31:0] exp;
        tbl[0] = '{16'hA5C3, 1, 0, 0, 0, 0, 0, 0, 16'hA5C3, 1, 0, 0};
        tbl[1] = '{16'h1234, 1, 0, 0, 0, 1, 0, 0, 16'h1234, 1, 0, 0};
        tbl[2] = '{16'hFFFF, 1, 0, 0, 0, 0, 0, 0, 16'h1234, 1, 1, 0};
        tbl[3] = '{16'h0000, 0, 0, 0, 0, 0, 1, 0, 16'h1234, 1, 0, 0};
        tbl[4] = '{16'h00FF, 1, 0, 0, 0, 1, 0, 0, 16'h00FF, 1, 0, 0};
        tbl[5] = '{16'hBEEF, 1, 7, 1, 0, 0, 0, 1, 16'hBEEF, 1, 0, 0};
        tbl[6] = '{16'hC0DE, 1, 5, 0, 1, 0, 0, 1, 16'hC0DE, 1, 0, 1};
        tbl[7] = '{16'h0000, 1, 0, 0, 0, 0, 1, 1, 16'h0000, 1, 0, 0};

        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk_on = 1'b1;
        check("reset_state", 32'(act_vec()), 32'd0);

        for (int r = 0; r < 8; r++) begin
            if (tbl[r].clear_before) pulse(1);
            if (tbl[r].drain_before) pulse(2);
            for (int p = 0; p < tbl[r].partial; p++) strobe_bit(1'($urandom_range(0, 1)), 1'b0, 1'b0);
            if (tbl[r].reset_mid) pulse(0);
            if (tbl[r].do_send) send_word(tbl[r].word, tbl[r].fs_restart, tbl[r].rdy_last);
            exp = 32'({tbl[r].exp_data, tbl[r].exp_valid, 1'b0, tbl[r].exp_ovr,
                       tbl[r].exp_ferr, 5'd0, 1'b0});
            check($sformatf("table_row%0d", r), 32'(act_vec()), exp);
        end

        // Enable low mid-frame freezes the receiver
        pulse(0);
        w = 16'h9D2B;
        for (int i = 15; i >= 10; i--) strobe_bit(w[i], 1'b0, 1'b0);
        for (int k = 0; k < 10; k++) begin
            bus.Enable_In            = 1'b0;
            bus.Shift_Data_Signal_In = 1'b1;
            bus.Serial_Data_In       = 1'($urandom_range(0, 1));
            bus.Frame_Start_In       = 1'($urandom_range(0, 1));
            tick();
        end
        idle_inputs();
        check("freeze_count", 32'(bus.Bit_Count_Out), 32'd6);
        check("freeze_busy", 32'(bus.Busy_Out), 32'd1);
        for (int i = 9; i >= 0; i--) strobe_bit(w[i], 1'b0, 1'b0);
        check("freeze_word", 32'(bus.Parallel_Data_Out), 32'h9D2B);
        check("freeze_valid", 32'(bus.Data_Valid_Out), 32'd1);
        check("freeze_ferr", 32'(bus.Frame_Error_Out), 32'd0);

`ifdef PARITY_CHECK_EN
        pulse(0);
        w = 16'h0001;
        for (int i = 15; i >= 0; i--) strobe_bit(w[i], 1'b0, 1'b0);
        strobe_bit(1'b0, 1'b0, 1'b0);
        check("parity_bad_flag", 32'(bus.Parity_Error_Out), 32'd1);
        check("parity_bad_word", 32'(bus.Parallel_Data_Out), 32'h0001);
        pulse(2);
        pulse(1);
        for (int i = 15; i >= 0; i--) strobe_bit(w[i], 1'b0, 1'b0);
        strobe_bit(1'b1, 1'b0, 1'b0);
        check("parity_good_flag", 32'(bus.Parity_Error_Out), 32'd0);
        check("parity_good_word", 32'(bus.Parallel_Data_Out), 32'h0001);
`endif

        // Randomized traffic, checked each cycle by the model
        for (int c = 0; c < 2000; c++) begin
            rst                      = ($urandom_range(0, 199) == 0);
            bus.Enable_In            = ($urandom_range(0, 9) != 0);
            bus.Shift_Data_Signal_In = ($urandom_range(0, 2) != 0);
            bus.Serial_Data_In       = 1'($urandom_range(0, 1));
            bus.Frame_Start_In       = ($urandom_range(0, 19) == 0);
            bus.Data_Ready_In        = ($urandom_range(0, 3) == 0);
            bus.Clear_Overrun_In     = ($urandom_range(0, 24) == 0);
            tick();
        end
        rst = 1'b0;
        idle_inputs();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
